// File: rtl/riscv_imem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: the word width, the
// NOP substituted for faulting fetches, and the response record.
package riscv_imem_resp_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] instr;
  } rsp_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and flush.
// Push to a full FIFO and pop from an empty one are ignored.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_imem_resp.sv
// Memory side of the fetch interface: credit-limited request accept, fixed
// latency RAM read pipeline, and a response FIFO that absorbs back-pressure.
module riscv_imem_resp
  import riscv_imem_resp_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [XLEN-1:0]              i_req_addr,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [XLEN-1:0]              o_rsp_instr,
  output logic                         o_rsp_err,
  input  logic                         i_flush,
  input  logic                         i_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] i_wr_addr,
  input  logic [XLEN-1:0]              i_wr_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    mem [MEM_WORDS];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0] pipe_err_q, pipe_err_d;
  logic [XLEN-1:0]    pipe_data_q [LATENCY];
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               accept, push, pop, addr_err;
  logic [AW-1:0]      word_idx;
  rsp_t               push_rsp, head_rsp;

  // A FIFO slot is reserved at accept, so outstanding plus buffered never exceeds DEPTH.
  assign o_req_ready = !i_flush &&
                       (({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
  assign accept   = i_req_valid && o_req_ready;
  assign word_idx = i_req_addr[AW+1:2];
  assign addr_err = (|i_req_addr[1:0]) || (|i_req_addr[XLEN-1:AW+2]);
  assign push     = pipe_vld_q[LATENCY-1];
  assign pop      = o_rsp_valid && i_rsp_ready;

  always_comb begin
    pipe_vld_d    = '0;
    pipe_err_d    = '0;
    pipe_vld_d[0] = accept;
    pipe_err_d[0] = addr_err;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
    end
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    if (i_flush) begin
      pipe_vld_d = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      inflight_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      inflight_q <= inflight_d;
    end
  end

  // Same-edge write and read of one word returns the old contents.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    pipe_data_q[0] <= mem[word_idx];
    for (int i = 1; i < LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  always_comb begin
    push_rsp.err   = pipe_err_q[LATENCY-1];
    push_rsp.instr = pipe_err_q[LATENCY-1] ? NOP_INSTR : pipe_data_q[LATENCY-1];
  end

  riscv_sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_flush),
    .data_i  (push_rsp),
    .data_o  (head_rsp),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Head storage is unreset, so gate the payload to zero when nothing is valid.
  assign o_rsp_valid = !fifo_empty;
  assign o_rsp_instr = o_rsp_valid ? head_rsp.instr : '0;
  assign o_rsp_err   = o_rsp_valid && head_rsp.err;

endmodule

// File: tb/tb_riscv_imem_resp.sv
// Directed bench for riscv_imem_resp: latency, back-pressure, error fetches,
// flush, write/read hazard and asynchronous reset.
module tb_riscv_imem_resp;

  logic        i_clk, i_rstn;
  logic        i_req_valid, o_req_ready;
  logic [31:0] i_req_addr;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_instr;
  logic        o_rsp_err, i_flush, i_wr_en;
  logic [9:0]  i_wr_addr;
  logic [31:0] i_wr_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int          idx;
  int          n_req;
  logic [31:0] addr_tab [8];
  logic [32:0] rsp_q [$];

  riscv_imem_resp #(.MEM_WORDS(1024), .LATENCY(2), .DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_instr (o_rsp_instr),
    .o_rsp_err   (o_rsp_err),
    .i_flush     (i_flush),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_write(input int a, input logic [31:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = 10'(a);
    i_wr_data = d;
    tick();
    i_wr_en   = 1'b0;
  endtask

  // Offers addr_tab[idx] while idx < n_req; logs every handshaken response.
  task automatic step_req();
    logic fire, take;
    i_req_valid = (idx < n_req);
    i_req_addr  = addr_tab[(idx < 8) ? idx : 0];
    #1;
    fire = i_req_valid && o_req_ready;
    take = o_rsp_valid && i_rsp_ready;
    if (take) rsp_q.push_back({o_rsp_err, o_rsp_instr});
    tick();
    if (fire) idx++;
  endtask

  function automatic logic [32:0] rsp_at(input int i);
    return (i < rsp_q.size()) ? rsp_q[i] : 33'h1_DEAD_DEAD;
  endfunction

  initial begin
    logic [31:0] exp2 [6];
    logic [31:0] exp3 [5];
    logic        err3 [5];
    logic [32:0] r;

    i_rstn = 1'b0; i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0;
    i_flush = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;

    // Reset state
    #2;
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_instr", o_rsp_instr, 32'd0);
    check("rst_rsp_err",   32'(o_rsp_err),   32'd0);
    tick(); tick();
    i_rstn = 1'b1;
    tick();
    check("rst_req_ready", 32'(o_req_ready), 32'd1);

    mem_write(0, 32'h11);
    mem_write(1, 32'h22);
    mem_write(2, 32'h33);
    mem_write(3, 32'h44);
    mem_write(5, 32'h55);

    // Back-to-back fetches: first response two edges after accept, one per cycle
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_req_valid = (k < 4);
      i_req_addr  = 32'(4 * k);
      #1;
      if (k < 4) check("t1_req_ready", 32'(o_req_ready), 32'd1);
      tick();
      if (k >= 2 && k <= 5) begin
        check("t1_rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("t1_rsp_instr", o_rsp_instr, 32'(17 * (k - 1)));
        check("t1_rsp_err",   32'(o_rsp_err), 32'd0);
      end else begin
        check("t1_rsp_idle", 32'(o_rsp_valid), 32'd0);
      end
    end

    // Back-pressure: six offered, four accepted while the consumer stalls
    addr_tab = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4, 32'd0, 32'd0};
    exp2     = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22};
    n_req = 6; idx = 0; rsp_q.delete();
    i_rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) step_req();
    check("t2_accepted", 32'(idx), 32'd4);
    check("t2_req_ready_low", 32'(o_req_ready), 32'd0);
    check("t2_head_valid", 32'(o_rsp_valid), 32'd1);
    check("t2_head_instr", o_rsp_instr, 32'h11);
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) step_req();
    i_req_valid = 1'b0;
    check("t2_all_accepted", 32'(idx), 32'd6);
    check("t2_rsp_count", 32'(rsp_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      r = rsp_at(i);
      check("t2_rsp_instr", r[31:0], exp2[i]);
      check("t2_rsp_err",   32'(r[32]), 32'd0);
    end

    // Faulting fetches keep latency and order among good ones
    addr_tab = '{32'd4, 32'd6, 32'd8, 32'h0000_1000, 32'd12, 32'd0, 32'd0, 32'd0};
    exp3     = '{32'h22, 32'h13, 32'h33, 32'h13, 32'h44};
    err3     = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    n_req = 5; idx = 0; rsp_q.delete();
    for (int c = 0; c < 15; c++) step_req();
    i_req_valid = 1'b0;
    check("t3_rsp_count", 32'(rsp_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      r = rsp_at(i);
      check("t3_rsp_instr", r[31:0], exp3[i]);
      check("t3_rsp_err",   32'(r[32]), 32'(err3[i]));
    end

    // Flush one cycle after three requests: nothing comes back
    i_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'(4 * k);
      tick();
    end
    i_flush = 1'b1;
    i_req_addr = 32'd12;
    #1;
    check("t4_ready_in_flush", 32'(o_req_ready), 32'd0);
    tick();
    i_flush = 1'b0;
    i_req_valid = 1'b0;
    check("t4_valid_after_flush", 32'(o_rsp_valid), 32'd0);
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_no_stale_rsp", 32'(o_rsp_valid), 32'd0);
    end
    i_req_valid = 1'b1;
    i_req_addr  = 32'd0;
    #1;
    check("t4_ready_again", 32'(o_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    check("t4_lat_e1", 32'(o_rsp_valid), 32'd0);
    tick();
    check("t4_lat_e2", 32'(o_rsp_valid), 32'd0);
    tick();
    check("t4_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("t4_rsp_instr", o_rsp_instr, 32'h11);
    tick();
    check("t4_drained", 32'(o_rsp_valid), 32'd0);

    // Same-edge write and read return old data; next read sees new data
    i_wr_en = 1'b1; i_wr_addr = 10'd5; i_wr_data = 32'hAB;
    i_req_valid = 1'b1; i_req_addr = 32'd20;
    tick();
    i_wr_en = 1'b0;
    tick();
    i_req_valid = 1'b0;
    check("t5_idle", 32'(o_rsp_valid), 32'd0);
    tick();
    check("t5_old_valid", 32'(o_rsp_valid), 32'd1);
    check("t5_old_data", o_rsp_instr, 32'h55);
    tick();
    check("t5_new_valid", 32'(o_rsp_valid), 32'd1);
    check("t5_new_data", o_rsp_instr, 32'hAB);
    tick();
    check("t5_drained", 32'(o_rsp_valid), 32'd0);

    // Reset with two in flight and two buffered
    i_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'(4 * k);
      tick();
    end
    i_req_valid = 1'b0;
    check("t6_buffered", 32'(o_rsp_valid), 32'd1);
    i_rstn = 1'b0;
    #1;
    check("t6_rst_valid", 32'(o_rsp_valid), 32'd0);
    check("t6_rst_instr", o_rsp_instr, 32'd0);
    check("t6_rst_err",   32'(o_rsp_err), 32'd0);
    tick(); tick();
    i_rstn = 1'b1;
    i_rsp_ready = 1'b1;
    tick();
    check("t6_ready_after_rst", 32'(o_req_ready), 32'd1);
    check("t6_no_ghost", 32'(o_rsp_valid), 32'd0);
    i_req_valid = 1'b1;
    i_req_addr  = 32'd8;
    tick();
    i_req_valid = 1'b0;
    check("t6_lat_e1", 32'(o_rsp_valid), 32'd0);
    tick();
    check("t6_lat_e2", 32'(o_rsp_valid), 32'd0);
    tick();
    check("t6_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("t6_rsp_instr", o_rsp_instr, 32'h33);
    tick();
    check("t6_drained", 32'(o_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
